// File: rtl/inta_sequencer_if.sv
// Signal bundle between the CPU-side INTA sequencer and the PIC / core it serves.
// master is the sequencer's view; slave is the PIC-plus-consumer side.
interface inta_sequencer_if;
  logic       int_req;
  logic       enable;
  logic [7:0] data_in;
  logic       inta_n;
  logic       lock_n;
  logic       busy;
  logic [7:0] vector;
  logic       vector_valid;
  logic       vector_ready;

  modport master (
    input  int_req, enable, data_in, vector_ready,
    output inta_n, lock_n, busy, vector, vector_valid
  );

  modport slave (
    output int_req, enable, data_in, vector_ready,
    input  inta_n, lock_n, busy, vector, vector_valid
  );
endinterface

// File: rtl/inta_sequencer.sv
// CPU-side end of the 8259A INT/INTA handshake: runs the two-pulse acknowledge,
// captures the vector on the last edge of pulse 2 and offers it via valid/ready.
module inta_sequencer #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input logic            clk,
  input logic            reset,
  inta_sequencer_if.master bus
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PULSE1 = 3'd1;
  localparam logic [2:0] GAP    = 3'd2;
  localparam logic [2:0] PULSE2 = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          int_s;
  logic          inta_n_r;
  logic          lock_n_r;
  logic          busy_r;
  logic [7:0]    vector_r;
  logic          valid_r;

  // INT comes from another clock domain, so it is only trusted after two flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      int_s <= 1'b0;
    end else begin
      sync1 <= bus.int_req;
      int_s <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      inta_n_r <= 1'b1;
      lock_n_r <= 1'b1;
      busy_r   <= 1'b0;
      vector_r <= 8'h00;
      valid_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (int_s && bus.enable) begin
            state    <= PULSE1;
            cnt      <= '0;
            inta_n_r <= 1'b0;
            lock_n_r <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        PULSE1: begin
          if (cnt == PULSE_LAST) begin
            state    <= GAP;
            cnt      <= '0;
            inta_n_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state    <= PULSE2;
            cnt      <= '0;
            inta_n_r <= 1'b0;
            lock_n_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // The PIC only guarantees the vector late in pulse 2, so sample on its final edge
        PULSE2: begin
          if (cnt == PULSE_LAST) begin
            state    <= HOLD;
            cnt      <= '0;
            vector_r <= bus.data_in;
            valid_r  <= 1'b1;
            inta_n_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (bus.vector_ready) begin
            state   <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          inta_n_r <= 1'b1;
          lock_n_r <= 1'b1;
          busy_r   <= 1'b0;
          valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inta_n       = inta_n_r;
  assign bus.lock_n       = lock_n_r;
  assign bus.busy         = busy_r;
  assign bus.vector       = vector_r;
  assign bus.vector_valid = valid_r;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scenario bench for inta_sequencer (PULSE_CYCLES=4, GAP_CYCLES=2); expected
// vectors go into a scoreboard queue when data_in is driven.
module tb_inta_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [7:0] sb[$];

  inta_sequencer_if bus ();

  inta_sequencer #(.PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bounded wait for vector_valid; also reports whether inta_n was seen low meanwhile
  task automatic wait_valid(input int max_cycles, output bit seen, output bit saw_low);
    seen    = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.inta_n == 1'b0) saw_low = 1'b1;
      if (bus.vector_valid == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pulse2(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.inta_n == 1'b0 && bus.lock_n == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_vector();
    bus.int_req = 1'b0;
    repeat (3) @(negedge clk);
    bus.vector_ready = 1'b1;
    @(negedge clk);
    bus.vector_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop_and_check(input string name);
    logic [7:0] exp;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: got vector %02h but scoreboard empty", name, bus.vector);
    end else begin
      exp = sb.pop_front();
      if (bus.vector !== exp) begin
        bad++;
        $display("[TB] FAIL %s: got vector %02h expected %02h", name, bus.vector, exp);
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    bit ever_valid;
    total++;
    if ({bus.inta_n, bus.lock_n, bus.busy, bus.vector_valid, bus.vector} !== {4'b1100, 8'h00}) begin
      bad++;
      $display("[TB] FAIL reset_state: got %b_%b_%b_%b_%02h expected 1_1_0_0_00",
               bus.inta_n, bus.lock_n, bus.busy, bus.vector_valid, bus.vector);
    end
    bus.enable  = 1'b1;
    bus.int_req = 1'b1;
    bus.data_in = 8'h99;
    wait_pulse2(40, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL reset_reach_pulse2: got timeout expected pulse 2");
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.inta_n, bus.lock_n, bus.busy, bus.vector_valid} !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL reset_async: got %b_%b_%b_%b expected 1_1_0_0",
               bus.inta_n, bus.lock_n, bus.busy, bus.vector_valid);
    end
    bus.int_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ever_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.vector_valid || !bus.inta_n) ever_valid = 1'b1;
    end
    total++;
    if (ever_valid !== 1'b0 || bus.vector !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_no_partial: got activity=%b vector=%02h expected 0 00",
               ever_valid, bus.vector);
    end
  endtask

  task automatic test_basic();
    logic exp_inta, exp_lock, exp_valid, exp_busy;
    bus.enable  = 1'b1;
    bus.data_in = 8'h48;
    sb.push_back(8'h48);
    @(negedge clk);
    bus.int_req = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk);
      #1;
      exp_inta  = !((e >= 2 && e <= 5) || (e >= 8 && e <= 11));
      exp_lock  = !(e >= 2 && e <= 7);
      exp_valid = (e >= 12);
      exp_busy  = (e >= 2);
      total++;
      if ({bus.inta_n, bus.lock_n, bus.vector_valid, bus.busy} !==
          {exp_inta, exp_lock, exp_valid, exp_busy}) begin
        bad++;
        $display("[TB] FAIL basic_edge%0d: got inta_n/lock_n/valid/busy=%b%b%b%b expected %b%b%b%b",
                 e, bus.inta_n, bus.lock_n, bus.vector_valid, bus.busy,
                 exp_inta, exp_lock, exp_valid, exp_busy);
      end
    end
    pop_and_check("basic_vector");
    release_vector();
    total++;
    if (bus.vector_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_release: got valid=%b busy=%b expected 0 0",
               bus.vector_valid, bus.busy);
    end
  endtask

  task automatic test_masked();
    bit seen, saw_low, leaked;
    bus.enable  = 1'b0;
    bus.int_req = 1'b1;
    bus.vector_ready = 1'b1;
    leaked = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.inta_n !== 1'b1 || bus.busy !== 1'b0 || bus.vector_valid !== 1'b0) leaked = 1'b1;
    end
    bus.vector_ready = 1'b0;
    total++;
    if (leaked) begin
      bad++;
      $display("[TB] FAIL masked_idle: got activity while masked expected none");
    end
    bus.enable  = 1'b1;
    bus.data_in = 8'h5A;
    sb.push_back(8'h5A);
    @(posedge clk);
    #1;
    total++;
    if (bus.inta_n !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL masked_start: got inta_n=%b busy=%b expected 0 1", bus.inta_n, bus.busy);
    end
    wait_valid(30, seen, saw_low);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL masked_valid: got timeout expected vector_valid");
    end
    pop_and_check("masked_vector");
    release_vector();
  endtask

  task automatic test_commitment();
    bit seen, saw_low, in_gap;
    bus.enable  = 1'b1;
    bus.data_in = 8'h33;
    bus.int_req = 1'b1;
    in_gap = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.lock_n && bus.inta_n) begin
        in_gap = 1'b1;
        break;
      end
    end
    total++;
    if (!in_gap) begin
      bad++;
      $display("[TB] FAIL commit_gap: got timeout expected GAP phase");
    end
    bus.int_req = 1'b0;
    bus.enable  = 1'b0;
    sb.push_back(8'h33);
    wait_valid(30, seen, saw_low);
    total++;
    if (!seen || !saw_low) begin
      bad++;
      $display("[TB] FAIL commit_pulse2: got valid=%b pulse2=%b expected 1 1", seen, saw_low);
    end
    pop_and_check("commit_vector");
    release_vector();
    bus.enable = 1'b1;
  endtask

  task automatic test_backpressure();
    bit seen, saw_low, moved;
    bus.enable  = 1'b1;
    bus.data_in = 8'h77;
    sb.push_back(8'h77);
    bus.int_req = 1'b1;
    wait_valid(40, seen, saw_low);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL bp_valid: got timeout expected vector_valid");
    end
    pop_and_check("bp_vector");
    bus.data_in = 8'hC3;
    moved = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.vector_valid !== 1'b1 || bus.vector !== 8'h77 || bus.inta_n !== 1'b1) moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++;
      $display("[TB] FAIL bp_hold: got change during backpressure expected stable vector 77");
    end
    bus.vector_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.vector_ready = 1'b0;
    total++;
    if (bus.vector_valid !== 1'b0 || bus.inta_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_accept: got valid=%b inta_n=%b expected 0 1", bus.vector_valid, bus.inta_n);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.inta_n !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_restart: got inta_n=%b expected 0", bus.inta_n);
    end
    bus.int_req = 1'b0;
    sb.push_back(8'hC3);
    wait_valid(30, seen, saw_low);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL bp_second_valid: got timeout expected vector_valid");
    end
    pop_and_check("bp_second_vector");
    release_vector();
  endtask

  task automatic test_bus_isolation();
    bit seen;
    bus.enable  = 1'b1;
    bus.data_in = 8'hFF;
    bus.int_req = 1'b1;
    wait_pulse2(40, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL iso_pulse2: got timeout expected pulse 2");
    end
    bus.int_req = 1'b0;
    repeat (3) @(negedge clk);
    bus.data_in = 8'h20;
    sb.push_back(8'h20);
    @(posedge clk);
    #1;
    bus.data_in = 8'hAA;
    total++;
    if (bus.vector_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL iso_valid: got valid=%b expected 1", bus.vector_valid);
    end
    pop_and_check("iso_vector");
    repeat (3) @(negedge clk);
    total++;
    if (bus.vector !== 8'h20) begin
      bad++;
      $display("[TB] FAIL iso_hold: got vector %02h expected 20", bus.vector);
    end
    release_vector();
    total++;
    if (bus.vector !== 8'h20 || bus.vector_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL iso_after_release: got vector %02h valid=%b expected 20 0",
               bus.vector, bus.vector_valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.int_req      = 1'b0;
    bus.enable       = 1'b0;
    bus.data_in      = 8'h00;
    bus.vector_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_masked();
    test_commitment();
    test_backpressure();
    test_bus_isolation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
